// File: rtl/txn_rec_pkg.sv
// Shared types and helpers for the transaction latency recorder.
// TXN_REC_ITER_EN selects whether FIFO entries carry the iteration count.
package txn_rec_pkg;

    localparam int unsigned TXN_CNT_W = 32;
    localparam int unsigned TXN_ID_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_FINISHED = 2'd2
    } txn_state_e;

    typedef struct packed {
        logic [TXN_ID_W-1:0]  id;
        logic [TXN_CNT_W-1:0] latency;
        logic [TXN_CNT_W-1:0] interval;
        logic [TXN_CNT_W-1:0] iters;
        logic                 aborted;
    } txn_rec_t;

`ifdef TXN_REC_ITER_EN
    typedef txn_rec_t txn_ent_t;
`else
    // Stored entry without the iteration field
    typedef struct packed {
        logic [TXN_ID_W-1:0]  id;
        logic [TXN_CNT_W-1:0] latency;
        logic [TXN_CNT_W-1:0] interval;
        logic                 aborted;
    } txn_ent_t;
`endif

    function automatic logic [TXN_CNT_W-1:0] sat_inc(input logic [TXN_CNT_W-1:0] v,
                                                     input logic [TXN_CNT_W-1:0] max_v);
        return (v >= max_v) ? max_v : v + TXN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rec_fifo.sv
// Synchronous record FIFO with a registered head entry; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module rec_fifo
    import txn_rec_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = txn_rec_t
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  T     din,
    input  logic ready,
    output logic valid,
    output T     dout,
    output logic full_c,
    output logic empty_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_nxt;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic           do_push;
    logic           do_pop;
    T               head_nxt;

    always_comb begin
        do_pop    = valid & ready;
        full_c    = (count == CW'(DEPTH));
        do_push   = push & (~full_c | do_pop);
        rd_nxt    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt = count;
        if (do_push & ~do_pop) begin
            count_nxt = count + CW'(1);
        end else if (~do_push & do_pop) begin
            count_nxt = count - CW'(1);
        end
        // New head comes from the write port when it lands on the next read slot
        head_nxt    = (do_push && (wr_ptr == rd_nxt)) ? din : mem[rd_nxt];
        empty_nxt_c = (count_nxt == '0);
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            valid  <= (count_nxt != '0);
            dout   <= head_nxt;
        end
    end

endmodule

// File: rtl/txn_latency_recorder.sv
// Records latency, start interval and loop iterations of each ap_ctrl_hs
// transaction into a FIFO. TXN_REC_ITER_EN enables iteration counting.
module txn_latency_recorder
    import txn_rec_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned ID_W       = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             iter_start,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [ID_W-1:0]  rec_id,
    output logic [CNT_W-1:0] rec_latency,
    output logic [CNT_W-1:0] rec_interval,
    output logic [CNT_W-1:0] rec_iters,
    output logic             rec_aborted,
    output logic             overflow,
    output logic [15:0]      drop_cnt,
    output logic             busy,
    output logic             flushed
);

    localparam int unsigned DROP_W = 16;
    localparam logic [TXN_CNT_W-1:0] CNT_MAX  = TXN_CNT_W'({CNT_W{1'b1}});
    localparam logic [TXN_CNT_W-1:0] DROP_MAX = TXN_CNT_W'({DROP_W{1'b1}});

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(TXN_CNT_W'(v), CNT_MAX));
    endfunction

    txn_state_e       state;
    txn_state_e       state_d;
    logic [CNT_W-1:0] lat_q;
    logic [CNT_W-1:0] int_q;
    logic [CNT_W-1:0] ival_q;
    logic [ID_W-1:0]  id_q;
    logic             first_q;

    logic             run_c;
    logic             idle_c;
    logic             done_c;
    logic             close_c;
    logic             abort_c;
    logic             open_c;
    logic             instant_c;
    logic             push_c;
    logic             drop_c;
    logic [CNT_W-1:0] open_ival_c;
    logic             fifo_full_c;
    logic             fifo_empty_nxt_c;
    txn_ent_t         ent_c;
    txn_ent_t         head;

`ifdef TXN_REC_ITER_EN
    logic [CNT_W-1:0] iters_q;
    logic [CNT_W-1:0] iters_close_c;
`else
    logic             unused_iter;
    assign unused_iter = iter_start;
`endif

    // Transaction decode, record assembly and next state
    always_comb begin
        run_c       = (state == ST_RUN);
        idle_c      = (state == ST_IDLE);
        done_c      = ap_done & ap_continue;
        close_c     = run_c & done_c;
        abort_c     = run_c & finish & ~done_c;
        open_c      = ap_start & ~finish & (idle_c | close_c);
        instant_c   = idle_c & open_c & done_c;
        push_c      = close_c | abort_c | instant_c;
        drop_c      = push_c & fifo_full_c & ~(rec_valid & rec_ready);
        open_ival_c = first_q ? '0 : int_q;

        ent_c          = '0;
        ent_c.id       = TXN_ID_W'(id_q);
        ent_c.latency  = instant_c ? '0 : TXN_CNT_W'(lat_q);
        ent_c.interval = TXN_CNT_W'(instant_c ? open_ival_c : ival_q);
        ent_c.aborted  = abort_c;
`ifdef TXN_REC_ITER_EN
        iters_close_c = iter_start ? cnt_inc(iters_q) : iters_q;
        ent_c.iters   = TXN_CNT_W'(instant_c ? CNT_W'(iter_start) : iters_close_c);
`endif

        state_d = state;
        case (state)
            ST_IDLE: begin
                if (finish) begin
                    state_d = ST_FINISHED;
                end else if (open_c & ~instant_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (finish) begin
                    state_d = ST_FINISHED;
                end else if (close_c & ~open_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_FINISHED;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            lat_q    <= '0;
            int_q    <= '0;
            ival_q   <= '0;
            id_q     <= '0;
            first_q  <= 1'b1;
            overflow <= 1'b0;
            drop_cnt <= '0;
            busy     <= 1'b0;
            flushed  <= 1'b0;
`ifdef TXN_REC_ITER_EN
            iters_q  <= '0;
`endif
        end else begin
            state   <= state_d;
            busy    <= (state_d == ST_RUN);
            flushed <= (state == ST_FINISHED) & fifo_empty_nxt_c;
            if (open_c) begin
                lat_q   <= CNT_W'(1);
                int_q   <= CNT_W'(1);
                ival_q  <= open_ival_c;
                first_q <= 1'b0;
            end else begin
                int_q <= cnt_inc(int_q);
                if (run_c) begin
                    lat_q <= cnt_inc(lat_q);
                end
            end
            if (push_c) begin
                id_q <= id_q + ID_W'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
                drop_cnt <= DROP_W'(sat_inc(TXN_CNT_W'(drop_cnt), DROP_MAX));
            end
`ifdef TXN_REC_ITER_EN
            if (open_c) begin
                iters_q <= CNT_W'(iter_start);
            end else if (run_c & iter_start) begin
                iters_q <= cnt_inc(iters_q);
            end
`endif
        end
    end

    rec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (txn_ent_t)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (push_c),
        .din         (ent_c),
        .ready       (rec_ready),
        .valid       (rec_valid),
        .dout        (head),
        .full_c      (fifo_full_c),
        .empty_nxt_c (fifo_empty_nxt_c)
    );

    assign rec_id       = ID_W'(head.id);
    assign rec_latency  = CNT_W'(head.latency);
    assign rec_interval = CNT_W'(head.interval);
    assign rec_aborted  = head.aborted;
`ifdef TXN_REC_ITER_EN
    assign rec_iters    = CNT_W'(head.iters);
`else
    assign rec_iters    = '0;
`endif

endmodule

// File: tb/tb_txn_latency_recorder.sv
// Self-checking bench for txn_latency_recorder: timestamp-based reference
// model checked every cycle, plus table-driven and hand-written sequences.
module tb_txn_latency_recorder;

    localparam int unsigned DEPTH = 8;
`ifdef TXN_REC_ITER_EN
    localparam bit ITER_ON = 1'b1;
`else
    localparam bit ITER_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        ap_start, ap_done, ap_continue, iter_start, finish, rec_ready;
    logic        rec_valid, rec_aborted, overflow, busy, flushed;
    logic [15:0] rec_id;
    logic [31:0] rec_latency, rec_interval, rec_iters;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    txn_latency_recorder dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .iter_start   (iter_start),
        .finish       (finish),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_id       (rec_id),
        .rec_latency  (rec_latency),
        .rec_interval (rec_interval),
        .rec_iters    (rec_iters),
        .rec_aborted  (rec_aborted),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .busy         (busy),
        .flushed      (flushed)
    );

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model (event timestamps, record queue) ----------------
    typedef struct {
        longint unsigned id;
        longint unsigned lat;
        longint unsigned ival;
        longint unsigned iters;
        bit              ab;
    } exp_rec_t;

    exp_rec_t        mq[$];
    bit              m_open, m_first, m_fin, m_ovf, m_flushed;
    longint unsigned m_id, m_drops, mcyc, m_t0, m_prev, m_iters, m_ival;

    task automatic m_push(input exp_rec_t r);
        if (mq.size() < DEPTH) begin
            mq.push_back(r);
        end else begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end
        m_id = (m_id + 1) % 65536;
    endtask

    always @(negedge clock) begin
        exp_rec_t        r;
        bit              was_open, was_fin, d;
        longint unsigned iv;
        if (!reset) begin
            mq.delete();
            m_open = 0; m_first = 1; m_fin = 0; m_ovf = 0; m_flushed = 0;
            m_id = 0; m_drops = 0;
            chk("rst_valid", rec_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_drop_cnt", drop_cnt, 0);
            chk("rst_flushed", flushed, 0);
            chk("rst_data", {rec_id, rec_latency, rec_interval, rec_iters, rec_aborted} == '0, 1);
        end else begin
            chk("m_valid", rec_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("m_id", rec_id, mq[0].id);
                chk("m_latency", rec_latency, mq[0].lat);
                chk("m_interval", rec_interval, mq[0].ival);
                chk("m_iters", rec_iters, mq[0].iters);
                chk("m_aborted", rec_aborted, mq[0].ab);
            end
            chk("m_busy", busy, m_open);
            chk("m_overflow", overflow, m_ovf);
            chk("m_drop_cnt", drop_cnt, m_drops);
            chk("m_flushed", flushed, m_flushed);

            was_open = m_open;
            was_fin  = m_fin;
            if (mq.size() > 0 && rec_ready) void'(mq.pop_front());
            d = ap_done && ap_continue;
            if (!was_fin) begin
                if (was_open) begin
                    if (d || finish) begin
                        r = '{m_id, mcyc - m_t0, m_ival, ITER_ON ? m_iters + iter_start : 0, !d};
                        m_push(r);
                        m_open = 0;
                    end else if (iter_start) begin
                        m_iters++;
                    end
                end
                if (finish) begin
                    m_fin = 1;
                end else if (ap_start && !m_open) begin
                    iv = m_first ? 0 : mcyc - m_prev;
                    m_first = 0;
                    m_prev  = mcyc;
                    if (!was_open && d) begin
                        r = '{m_id, 0, iv, ITER_ON ? longint'(iter_start) : 0, 0};
                        m_push(r);
                    end else begin
                        m_open  = 1;
                        m_t0    = mcyc;
                        m_ival  = iv;
                        m_iters = iter_start;
                    end
                end
            end
            m_flushed = was_fin && (mq.size() == 0);
        end
        mcyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        ap_start = 0; ap_done = 0; ap_continue = 1; iter_start = 0; finish = 0; rec_ready = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        clear_inputs();
        repeat (3) tick();
        reset = 1;
        cyc = 0;
    endtask

    typedef struct {
        int              ts;
        int              td;
        int              nit;
        longint unsigned elat;
        longint unsigned eival;
    } txn_vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_vec_t tv[6];
        reset = 0;
        clear_inputs();

        // ---- table-driven transactions, reader stalled ----
        tv[0] = '{10, 25, 3, 15, 0};
        tv[1] = '{40, 47, 0, 7, 30};
        tv[2] = '{52, 60, 1, 8, 12};
        tv[3] = '{60, 70, 2, 10, 8};
        tv[4] = '{80, 80, 0, 0, 20};
        tv[5] = '{90, 93, 1, 3, 10};
        do_reset();
        for (int c = 0; c < 100; c++) begin
            ap_start = 0; ap_done = 0; iter_start = 0;
            foreach (tv[k]) begin
                if (tv[k].ts == c) ap_start = 1;
                if (tv[k].td == c) ap_done = 1;
                if (c > tv[k].ts && c <= tv[k].ts + tv[k].nit) iter_start = 1;
            end
            if (c == 10) chk("busy_before_t0", busy, 0);
            if (c == 11) chk("busy_t0p1", busy, 1);
            if (c == 25) begin chk("busy_t1", busy, 1); chk("valid_t1", rec_valid, 0); end
            if (c == 26) begin
                chk("busy_after_t1", busy, 0);
                chk("valid_t1p1", rec_valid, 1);
                chk("first_id", rec_id, 0);
                chk("first_latency", rec_latency, 15);
            end
            if (c == 60 || c == 61) chk("busy_b2b", busy, 1);
            if (c == 81) chk("busy_instant", busy, 0);
            tick();
        end
        clear_inputs();
        for (int r = 0; r < 2; r++) begin
            chk("hold_id", rec_id, 0);
            chk("hold_latency", rec_latency, 15);
            tick();
        end
        rec_ready = 1;
        foreach (tv[k]) begin
            chk("tbl_valid", rec_valid, 1);
            chk("tbl_id", rec_id, k);
            chk("tbl_latency", rec_latency, tv[k].elat);
            chk("tbl_interval", rec_interval, tv[k].eival);
            chk("tbl_iters", rec_iters, ITER_ON ? tv[k].nit : 0);
            chk("tbl_aborted", rec_aborted, 0);
            tick();
        end
        rec_ready = 0;
        chk("tbl_empty", rec_valid, 0);

        // ---- overflow: 10 transactions into 8 entries, then push-with-pop when full ----
        do_reset();
        for (int n = 0; n < 10; n++) begin
            ap_start = 1; tick();
            ap_start = 0; tick();
            ap_done = 1; tick();
            ap_done = 0; tick();
        end
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop_cnt", drop_cnt, 2);
        chk("ovf_head_id", rec_id, 0);
        ap_start = 1; tick();
        ap_start = 0; tick();
        ap_done = 1; rec_ready = 1; tick();
        ap_done = 0; rec_ready = 0;
        chk("fullpop_drop_cnt", drop_cnt, 2);
        chk("fullpop_head_id", rec_id, 1);
        rec_ready = 1;
        for (int k = 0; k < 8; k++) begin
            chk("ovf_rd_valid", rec_valid, 1);
            chk("ovf_rd_id", rec_id, (k < 7) ? k + 1 : 10);
            tick();
        end
        rec_ready = 0;
        chk("ovf_rd_empty", rec_valid, 0);

        // ---- finish cuts an open transaction; later starts ignored ----
        do_reset();
        for (int c = 0; c < 26; c++) begin
            ap_start = (c == 2) || (c == 10) || (c == 20);
            ap_done  = (c == 6) || (c == 22);
            finish   = (c >= 15);
            if (c == 16) chk("fin_busy", busy, 0);
            tick();
        end
        ap_start = 0; ap_done = 0;
        chk("fin_rec0_id", rec_id, 0);
        chk("fin_rec0_latency", rec_latency, 4);
        chk("fin_rec0_aborted", rec_aborted, 0);
        chk("fin_not_flushed", flushed, 0);
        rec_ready = 1; tick();
        chk("fin_abort_valid", rec_valid, 1);
        chk("fin_abort_id", rec_id, 1);
        chk("fin_abort_flag", rec_aborted, 1);
        chk("fin_abort_latency", rec_latency, 5);
        chk("fin_abort_interval", rec_interval, 8);
        chk("fin_still_not_flushed", flushed, 0);
        tick();
        rec_ready = 0;
        chk("fin_drained", rec_valid, 0);
        chk("fin_flushed", flushed, 1);
        tick();
        chk("fin_flushed_sticky", flushed, 1);

        // ---- reset asserted mid-transaction with records buffered ----
        do_reset();
        for (int c = 0; c < 16; c++) begin
            ap_start = (c == 1) || (c == 5) || (c == 9) || (c == 13);
            ap_done  = (c == 3) || (c == 7) || (c == 11);
            tick();
        end
        clear_inputs();
        chk("mid_busy", busy, 1);
        chk("mid_valid", rec_valid, 1);
        #2 reset = 0;
        #1;
        chk("async_valid", rec_valid, 0);
        chk("async_busy", busy, 0);
        tick(); tick();
        reset = 1;
        cyc = 0;
        for (int c = 0; c < 5; c++) begin
            ap_start = (c == 2);
            ap_done  = (c == 4);
            tick();
        end
        clear_inputs();
        chk("post_rst_id", rec_id, 0);
        chk("post_rst_latency", rec_latency, 2);
        chk("post_rst_interval", rec_interval, 0);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int unsigned rp;
            rp = (c < 1200) ? 5 : 70;
            ap_start    = ($urandom_range(99) < 30);
            ap_done     = ($urandom_range(99) < 25);
            ap_continue = ($urandom_range(99) < 85);
            iter_start  = ($urandom_range(99) < 30);
            rec_ready   = ($urandom_range(99) < rp);
            tick();
        end
        finish = 1;
        rec_ready = 1;
        for (int c = 0; c < 30; c++) begin
            ap_start = ($urandom_range(99) < 50);
            ap_done  = ($urandom_range(99) < 50);
            tick();
        end
        chk("rand_flushed", flushed, 1);
        chk("rand_empty", rec_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/txn_latency_recorder.md
# txn_latency_recorder

Synthesizable transaction recorder that sits directly downstream of an HLS top's `ap_ctrl_hs` handshake and sequential-loop FSM. It measures per-transaction latency, start-to-start interval and loop iteration count, then buffers one record per transaction in a small FIFO for a valid/ready reader. The reader is a cosim dumper or an on-chip debug port. It is the hardware counterpart of the simulation-only module-status and seq-loop CSV dumping.

## Interface
- `CNT_W`, 32: width of the latency, interval and iteration counters.
- `ID_W`, 16: width of the transaction sequence number.
- `FIFO_DEPTH`, 8: number of record entries; must be a power of two, ≥2.
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ap_start` in 1: DUT start.
- `ap_done` in 1: DUT done.
- `ap_continue` in 1: DUT continue; tie high when the DUT has none.
- `iter_start` in 1: one-cycle pulse when the DUT FSM enters the loop iteration start state.
- `finish` in 1: end of run; level, sticky externally.
- `rec_valid` out 1: head record available.
- `rec_ready` in 1: reader accepts the head record.
- `rec_id` out ID_W: transaction sequence number, starting at 0.
- `rec_latency` out CNT_W: cycles from start to done.
- `rec_interval` out CNT_W: cycles since the previous start; 0 for the first transaction.
- `rec_iters` out CNT_W: loop iterations observed in the transaction.
- `rec_aborted` out 1: transaction was cut off by `finish`.
- `overflow` out 1: sticky; at least one record was dropped.
- `drop_cnt` out 16: number of dropped records, saturating.
- `busy` out 1: a transaction is open.
- `flushed` out 1: `finish` has been seen and the FIFO is empty.

## Operation
- The FSM has three states: IDLE, RUN, FINISHED.
- IDLE with `ap_start`=1 opens a transaction; cycle t0.
  - Clear the latency and iteration counters.
  - Latch `rec_interval` from the interval counter, or 0 if this is the first transaction.
  - Restart the interval counter.
  - Next state is RUN.
- RUN with `ap_done & ap_continue` closes the transaction; cycle t1.
  - Push the record with latency = t1−t0.
  - Increment the ID, which wraps modulo 2^ID_W.
  - Next state is IDLE.
- Done and a new start in the same cycle: close the current transaction, then open the next with t0 = that cycle. Next state is RUN.
- Done and start both high in IDLE: open and close in the same cycle with latency 0. Next state is IDLE.
- `ap_start` while in RUN with no done: ignored. Only one transaction is outstanding.
- `iter_start` counts only in RUN, and in the opening cycle of a transaction.
- Every counter saturates at all-ones and never wraps.
- `finish` in RUN: push the open record with `rec_aborted`=1 and latency = cycles so far. Then go to FINISHED.
- `finish` in IDLE: go to FINISHED. FINISHED is left only by reset.
- FINISHED ignores all DUT inputs. The FIFO keeps draining.
- Push while the FIFO is full and no pop in the same cycle:
  - the record is dropped;
  - `overflow` sets;
  - `drop_cnt` increments, saturating;
  - the ID still increments.
- Push while the FIFO is full with a pop in the same cycle: the push is accepted.
- Reset values:
  - State IDLE; all counters 0; ID 0; FIFO empty.
  - `rec_valid`=0, `busy`=0, `overflow`=0, `drop_cnt`=0, `flushed`=0.
  - All `rec_*` data outputs 0.
- Reset asserted mid-transaction discards the open transaction and all buffered records immediately.

## Timing
- A record pushed in cycle t1 presents `rec_valid`=1 from cycle t1+1, since the FIFO output is registered.
- `rec_valid & rec_ready` in cycle n pops the head; the next entry is presented in cycle n+1.
- `rec_*` data must remain stable while `rec_valid`=1 and `rec_ready`=0.
- `busy` is registered: high from t0+1 through t1.
- `flushed` rises the cycle after both conditions hold: FINISHED and FIFO empty.
- Throughput: one record per cycle in both directions.

## Configuration
- `TXN_REC_ITER_EN` defined:
  - iteration counting is present;
  - `rec_iters` is stored in the FIFO.
- `TXN_REC_ITER_EN` undefined:
  - `iter_start` is unused;
  - `rec_iters` is tied to 0;
  - the FIFO entry width excludes the iteration field.

## Structure
- Package `txn_rec_pkg` holds:
  - the state enum `txn_state_e`;
  - the record struct `txn_rec_t` (id, latency, interval, iters, aborted);
  - the saturating-increment function.
- Sub-module `rec_fifo` is a synchronous FIFO.
  - Parameters: depth and `txn_rec_t` payload.
  - Registered output, full/empty flags, push-when-full-with-pop support.

## Test plan
- Start at cycle 10, done at 25, `iter_start` ×3 → record id 0, latency 15, interval 0, iters 3, aborted 0; `rec_valid` at cycle 26.
- Second start at cycle 40, done at 47 → id 1, latency 7, interval 30.
- Done and start in the same cycle 60 → record closed with correct latency; `busy` stays high; next t0 = 60.
- FIFO_DEPTH=8, `rec_ready`=0, 10 transactions → 8 stored; `overflow`=1; `drop_cnt`=2; later reads return ids 0–7.
- `finish` at latency 5 in RUN → aborted record with latency 5. A later `ap_start` is ignored. `flushed`=1 the cycle after the last pop.
- Reset asserted mid-RUN with 3 records buffered → `rec_valid`=0 and `busy`=0 immediately. After release the next record has id 0.
